// File: rtl/ksa_if.sv
// ARC4 key-scheduling bus: en/rdy start handshake, secret key and single-port S-memory port.
// master drives requests and read data; slave is the ksa engine.
interface ksa_if #(
  parameter int unsigned KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );

  modport slave (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa.sv
// ARC4 key scheduling: permutes the 256-byte S memory in place using the latched key.
// Define KSA_DBG_EN to add the dbg_i/dbg_j/dbg_state observation outputs.
module ksa #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  ksa_if.slave       bus
`ifdef KSA_DBG_EN
  ,
  output logic [7:0] dbg_i,
  output logic [7:0] dbg_j,
  output logic [3:0] dbg_state
`endif
);

  localparam int unsigned KidxW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StRdi  = 4'd1,
    StWti  = 4'd2,
    StCj   = 4'd3,
    StRdj  = 4'd4,
    StWtj  = 4'd5,
    StLj   = 4'd6,
    StWrj  = 4'd7,
    StWri  = 4'd8
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [KidxW-1:0]       kidx_q, kidx_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [7:0]             addr_q, wrdata_q;
  logic [7:0]             addr, wrdata;
  logic                   wren;
  logic [7:0]             key_byte;

  // Key byte 0 is the most significant byte of the key.
  always_comb begin
    key_byte = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KidxW'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    si_d    = si_q;
    sj_d    = sj_q;
    // addr/wrdata hold their last value in states that do not drive them
    addr    = addr_q;
    wrdata  = wrdata_q;
    wren    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          key_d   = bus.key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = StRdi;
        end
      end
      StRdi: begin
        addr    = i_q;
        state_d = StWti;
      end
      StWti: begin
        addr    = i_q;
        state_d = StCj;
      end
      StCj: begin
        si_d    = bus.rddata;
        j_d     = j_q + bus.rddata + key_byte;
        state_d = StRdj;
      end
      StRdj: begin
        addr    = j_q;
        state_d = StWtj;
      end
      StWtj: begin
        addr    = j_q;
        state_d = StLj;
      end
      StLj: begin
        sj_d    = bus.rddata;
        state_d = StWrj;
      end
      StWrj: begin
        addr    = j_q;
        wrdata  = si_q;
        wren    = 1'b1;
        state_d = StWri;
      end
      StWri: begin
        addr    = i_q;
        wrdata  = sj_q;
        wren    = 1'b1;
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == KidxW'(KEY_BYTES - 1)) ? '0 : kidx_q + KidxW'(1);
        state_d = (i_q == 8'hFF) ? StIdle : StRdi;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      kidx_q   <= '0;
      key_q    <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kidx_q   <= kidx_d;
      key_q    <= key_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      addr_q   <= addr;
      wrdata_q <= wrdata;
    end
  end

  assign bus.rdy    = (state_q == StIdle);
  assign bus.addr   = addr;
  assign bus.wrdata = wrdata;
  assign bus.wren   = wren;

`ifdef KSA_DBG_EN
  assign dbg_i     = i_q;
  assign dbg_j     = j_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: software ARC4 KSA model, expected-write scoreboard,
// synchronous-read S memory and directed key vectors.
module tb_ksa;
  localparam int unsigned KB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic init_mem;
  always #5 clk = ~clk;

  ksa_if #(.KEY_BYTES(KB)) bus ();

`ifdef KSA_DBG_EN
  logic [7:0] dbg_i, dbg_j;
  logic [3:0] dbg_state;
`endif

  ksa #(.KEY_BYTES(KB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef KSA_DBG_EN
    ,
    .dbg_i     (dbg_i),
    .dbg_j     (dbg_j),
    .dbg_state (dbg_state)
`endif
  );

  // Single-port S memory: data for the address of cycle N is on rddata during cycle N+1.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Software KSA: final S, j per iteration, and the ordered list of memory writes.
  logic [7:0] model_s [256];
  logic [7:0] model_j [256];
  logic [7:0] exp_addr [$];
  logic [7:0] exp_data [$];

  task automatic model_run(input logic [23:0] k, input int iters);
    logic [7:0]  j, t;
    logic [23:0] sh;
    j = 8'd0;
    for (int x = 0; x < 256; x++) model_s[x] = 8'(x);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < iters; i++) begin
      sh = k << (8 * (i % 3));
      j  = j + model_s[i] + sh[23:16];
      exp_addr.push_back(j);
      exp_data.push_back(model_s[i]);
      exp_addr.push_back(8'(i));
      exp_data.push_back(model_s[j]);
      t          = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
      model_j[i] = j;
    end
  endtask

  // Compare process: every DUT write must be the next one the model predicts.
  int wr_cnt = 0;
  int busy_k = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_k = 0;
    end else begin
      if (bus.wren) begin
        wr_cnt++;
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, required no write",
                   bus.addr, bus.wrdata);
        end else begin
          check("wr_addr", bus.addr, exp_addr.pop_front());
          check("wr_data", bus.wrdata, exp_data.pop_front());
        end
      end
      if (!bus.rdy) begin
`ifdef KSA_DBG_EN
        check("dbg_i", dbg_i, busy_k / 8);
        if (busy_k % 8 == 3) check("dbg_j", dbg_j, model_j[busy_k / 8]);
`endif
        busy_k++;
      end else begin
        busy_k = 0;
      end
    end
  end

  task automatic init_s();
    @(negedge clk) init_mem = 1'b1;
    @(negedge clk) init_mem = 1'b0;
  endtask

  task automatic final_compare();
    for (int x = 0; x < 256; x++) check("final_S", mem[x], model_s[x]);
  endtask

  // One full pass; counts negedges with rdy low after the accepting edge.
  task automatic run_pass(input logic [23:0] k, input bit pulses, input bit early_chk);
    int lo;
    int w0;
    lo = 0;
    w0 = wr_cnt;
    @(negedge clk);
    bus.key = k;
    bus.en  = 1'b1;
    @(posedge clk);
    #1;
    bus.en  = 1'b0;
    bus.key = 24'hA5C3E7;
    for (int c = 0; c < 2100; c++) begin
      @(negedge clk);
      if (bus.rdy) break;
      if (early_chk && lo == 0) begin
        check("first_addr", bus.addr, 0);
        check("first_wren", bus.wren, 0);
      end
      if (early_chk && lo == 24) begin
        check("S2_after_i2", mem[2], 8'h03);
        check("S3_after_i2", mem[3], 8'h02);
      end
      if (pulses && (lo == 5 || lo == 900)) begin
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
      end
      lo++;
    end
    check("rdy_low_cycles", lo, 2048);
    check("wren_cycles", wr_cnt - w0, 512);
    check("writes_left", exp_addr.size(), 0);
  endtask

  initial begin
    int w0;
    rst_n    = 1'b0;
    init_mem = 1'b0;
    bus.en   = 1'b0;
    bus.key  = '0;
    #12;
    check("reset_rdy", bus.rdy, 1);
    check("reset_wren", bus.wren, 0);
    check("reset_addr", bus.addr, 0);
`ifdef KSA_DBG_EN
    check("reset_dbg_i", dbg_i, 0);
    check("reset_dbg_j", dbg_j, 0);
    check("reset_dbg_state", dbg_state, 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Idle with en low: no memory traffic.
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("idle_writes", wr_cnt - w0, 0);
    check("idle_rdy", bus.rdy, 1);
    check("idle_addr", bus.addr, 0);

    // Pin the model with hand-worked first iterations.
    model_run(24'h000000, 3);
    check("model0_S2", model_s[2], 8'h03);
    check("model0_S3", model_s[3], 8'h02);
    model_run(24'h1E4600, 3);
    check("model1_S0", model_s[0], 8'h1E);
    check("model1_S1", model_s[1], 8'h65);
    check("model1_S2", model_s[2], 8'h67);
    check("model1_S1E", model_s[8'h1E], 8'h00);
    check("model1_S65", model_s[8'h65], 8'h01);
    check("model1_S67", model_s[8'h67], 8'h02);
    model_run(24'h000001, 3);
    check("model2_S2", model_s[2], 8'h04);
    check("model2_S4", model_s[4], 8'h02);

    // Key all zero.
    init_s();
    model_run(24'h000000, 256);
    run_pass(24'h000000, 1'b0, 1'b1);
    final_compare();

    // Key 1E4600.
    init_s();
    model_run(24'h1E4600, 256);
    run_pass(24'h1E4600, 1'b0, 1'b0);
    final_compare();

    // Same key with en pulses while busy: must be a single pass, same result.
    init_s();
    model_run(24'h1E4600, 256);
    run_pass(24'h1E4600, 1'b1, 1'b0);
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("after_pass_writes", wr_cnt - w0, 0);
    check("after_pass_rdy", bus.rdy, 1);
    final_compare();

    // Reset mid-pass, then a clean pass with key 000001.
    init_s();
    model_run(24'h1E4600, 256);
    @(negedge clk);
    bus.key = 24'h1E4600;
    bus.en  = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rdy", bus.rdy, 1);
    check("abort_wren", bus.wren, 0);
    check("abort_addr", bus.addr, 0);
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk) rst_n = 1'b1;
    init_s();
    model_run(24'h000001, 256);
    run_pass(24'h000001, 1'b0, 1'b0);
    final_compare();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
